// File: rtl/cln_key_pkg.sv
// -----------------------------------------------------------------------------
// cln_key_pkg
// Shared definitions for the cln key loader:
//   - cln geometry (N, STAGES) and the stream beat width (WORD_W)
//   - derived key sizes: KB bits per K bus, KEY_W for the whole key,
//     BEATS stream beats per key, CNT_W bits for the beat counter
//   - loader FSM state encoding
//   - helper that detects the final beat index
// -----------------------------------------------------------------------------
package cln_key_pkg;

    localparam int N        = 16;
    localparam int STAGES   = 6;
    localparam int WORD_W   = 8;

    localparam int KB       = (N * STAGES) / 2;
    localparam int KEY_W    = 3 * KB;
    localparam int BEATS    = (KEY_W + WORD_W - 1) / WORD_W;
    localparam int CNT_W    = $clog2(BEATS);
    // Shadow storage is a whole number of beats; bits above KEY_W are pad.
    localparam int SHADOW_W = BEATS * WORD_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } state_e;

    // True when the beat counter points at the last beat of a key.
    function automatic logic is_final_beat(input logic [CNT_W-1:0] cnt);
        return (cnt == CNT_W'(BEATS - 1));
    endfunction

endpackage

// File: rtl/cln_key_shadow.sv
// -----------------------------------------------------------------------------
// cln_key_shadow
// Shadow register that assembles a key one beat at a time before it is
// committed to the live K buses. Beat idx lands at bits [idx*WORD_W +: WORD_W]
// (LSB-first); pad bits above KEY_W are stored but never presented.
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset (clears the shadow)
//   we_i      in   write enable for one beat
//   idx_i     in   beat index to write
//   data_i    in   beat data
//   shadow_o  out  assembled key {k2,k1,k0}
// -----------------------------------------------------------------------------
module cln_key_shadow
    import cln_key_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [CNT_W-1:0]  idx_i,
    input  logic [WORD_W-1:0] data_i,
    output logic [KEY_W-1:0]  shadow_o
);

    logic [SHADOW_W-1:0] shadow_q;

    for (genvar b = 0; b < BEATS; b++) begin : g_beat
        // Per-beat slot: written only when its own index is addressed.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                shadow_q[b*WORD_W +: WORD_W] <= {WORD_W{1'b0}};
            end else if (we_i && (idx_i == CNT_W'(b))) begin
                shadow_q[b*WORD_W +: WORD_W] <= data_i;
            end
        end
    end

    assign shadow_o = shadow_q[KEY_W-1:0];

endmodule

// File: rtl/cln_key_loader.sv
// -----------------------------------------------------------------------------
// cln_key_loader
// Sequences key configuration for the cln permutation network. A key arrives
// as BEATS stream beats over valid/ready, is assembled in a shadow register,
// and is committed atomically to k0/k1/k2 in a single cycle. An optional lock
// blocks every further reload until reset.
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   start               request a load (honoured in IDLE only)
//   lock_req            captured with an accepted start; locks after commit
//   abort               cancels a load in progress
//   s_valid/s_ready     beat handshake; s_data beat, s_last final-beat marker
//   k0/k1/k2            live key buses to cln
//   key_valid           a key has been committed since reset
//   busy                FSM is not IDLE
//   locked              reloads are disabled
//   err                 sticky protocol error, cleared by an accepted start
// -----------------------------------------------------------------------------
module cln_key_loader
    import cln_key_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              lock_req,
    input  logic              abort,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_last,
    output logic [KB-1:0]     k0,
    output logic [KB-1:0]     k1,
    output logic [KB-1:0]     k2,
    output logic              key_valid,
    output logic              busy,
    output logic              locked,
    output logic              err
);

    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                lock_pend_q;
    logic                err_q;
    logic                locked_q;
    logic                key_valid_q;
    logic [KB-1:0]       k0_q;
    logic [KB-1:0]       k1_q;
    logic [KB-1:0]       k2_q;
    logic                beat_acc_s;
    logic [KEY_W-1:0]    shadow_s;

    // abort masks ready so a beat presented in the abort cycle is not consumed.
    assign s_ready    = (state_q == LOAD) & ~abort;
    assign beat_acc_s = s_valid & s_ready;

    cln_key_shadow u_shadow (
        .clk      (clk),
        .rst_n    (rst_n),
        .we_i     (beat_acc_s),
        .idx_i    (cnt_q),
        .data_i   (s_data),
        .shadow_o (shadow_s)
    );

    // Loader FSM, beat counter, error/lock flags and the live key registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            lock_pend_q <= 1'b0;
            err_q       <= 1'b0;
            locked_q    <= 1'b0;
            key_valid_q <= 1'b0;
            k0_q        <= {KB{1'b0}};
            k1_q        <= {KB{1'b0}};
            k2_q        <= {KB{1'b0}};
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (locked_q) begin
                            err_q <= 1'b1;
                        end else begin
                            state_q     <= LOAD;
                            cnt_q       <= {CNT_W{1'b0}};
                            err_q       <= 1'b0;
                            lock_pend_q <= lock_req;
                        end
                    end
                end
                LOAD: begin
                    if (abort) begin
                        state_q <= IDLE;
                    end else if (beat_acc_s) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (is_final_beat(cnt_q)) begin
                            if (s_last) begin
                                state_q <= COMMIT;
                            end else begin
                                err_q   <= 1'b1;
                                state_q <= IDLE;
                            end
                        end else if (s_last) begin
                            // Early s_last: the partial shadow is never committed.
                            err_q   <= 1'b1;
                            state_q <= IDLE;
                        end
                    end
                end
                COMMIT: begin
                    // The only place the live key changes: all three buses at once.
                    k0_q        <= shadow_s[0*KB +: KB];
                    k1_q        <= shadow_s[1*KB +: KB];
                    k2_q        <= shadow_s[2*KB +: KB];
                    key_valid_q <= 1'b1;
                    locked_q    <= lock_pend_q;
                    state_q     <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign k0        = k0_q;
    assign k1        = k1_q;
    assign k2        = k2_q;
    assign key_valid = key_valid_q;
    assign busy      = (state_q != IDLE);
    assign locked    = locked_q;
    assign err       = err_q;

endmodule
